// File: rtl/turn_controller.sv
// Game-phase sequencer: title -> player -> enemy -> resolve, with turn counting,
// board rotation and an enemy-phase watchdog. Phase changes land only on frame starts.
module turn_controller #(
  parameter int MAX_TURNS = 10,
  parameter int TIMEOUT   = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start_in,
  input  logic       start_in,
  input  logic       confirm_in,
  input  logic       rotate_btn_in,
  input  logic       enemy_busy_in,
  input  logic       enemy_finished_in,
  output logic [3:0] state_out,
  output logic [3:0] turn_out,
  output logic [1:0] rotate_out,
  output logic       phase_change_out,
  output logic       timeout_out
);

  typedef enum logic [3:0] {
    S_OVER    = 4'b0000,
    S_TITLE   = 4'b0001,
    S_PLAYER  = 4'b0010,
    S_RESOLVE = 4'b0100,
    S_ENEMY   = 4'b1000
  } state_t;

  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]      TURN_LAST = 4'(MAX_TURNS - 1);

  state_t           r_state, w_state_nxt;
  logic             r_pending, w_pending_nxt;
  logic [3:0]       r_turn, w_turn_nxt;
  logic [1:0]       r_rotate, w_rotate_nxt;
  logic             r_phase_change, w_phase_change_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_seen_busy, w_seen_busy_nxt;
  logic             w_event;
  logic             w_tmo_hit;
  logic             w_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_TITLE;
      r_pending      <= 1'b0;
      r_turn         <= 4'd0;
      r_rotate       <= 2'd0;
      r_phase_change <= 1'b0;
      r_timeout      <= 1'b0;
      r_cnt          <= '0;
      r_seen_busy    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pending      <= w_pending_nxt;
      r_turn         <= w_turn_nxt;
      r_rotate       <= w_rotate_nxt;
      r_phase_change <= w_phase_change_nxt;
      r_timeout      <= w_timeout_nxt;
      r_cnt          <= w_cnt_nxt;
      r_seen_busy    <= w_seen_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_turn_nxt         = r_turn;
    w_rotate_nxt       = r_rotate;
    w_phase_change_nxt = 1'b0;
    w_timeout_nxt      = r_timeout;
    w_cnt_nxt          = r_cnt;
    w_seen_busy_nxt    = r_seen_busy;
    w_event            = 1'b0;
    w_tmo_hit          = (r_state == S_ENEMY) && !r_seen_busy && (r_cnt == CNT_LAST);

    case (r_state)
      S_TITLE, S_OVER: w_event = start_in;
      S_PLAYER: begin
        w_event = confirm_in;
        if (rotate_btn_in) w_rotate_nxt = r_rotate + 2'd1;
      end
      S_ENEMY: begin
        w_event = enemy_finished_in | w_tmo_hit;
        if (enemy_busy_in) w_seen_busy_nxt = 1'b1;
        if (r_cnt != CNT_LAST) w_cnt_nxt = r_cnt + 1'b1;
        // A finish in the same cycle, or one already latched, wins over the watchdog.
        if (w_tmo_hit && !enemy_finished_in && !r_pending) w_timeout_nxt = 1'b1;
      end
      S_RESOLVE: w_event = 1'b1;
      default: w_event = 1'b0;
    endcase

    w_fire        = frame_start_in && (r_pending || w_event);
    w_pending_nxt = r_pending | w_event;

    if (w_fire) begin
      w_pending_nxt      = 1'b0;
      w_phase_change_nxt = 1'b1;
      case (r_state)
        S_TITLE: begin
          w_state_nxt   = S_PLAYER;
          w_turn_nxt    = 4'd0;
          w_rotate_nxt  = 2'd0;
          w_timeout_nxt = 1'b0;
        end
        S_PLAYER: begin
          w_state_nxt     = S_ENEMY;
          w_cnt_nxt       = '0;
          w_seen_busy_nxt = 1'b0;
        end
        S_ENEMY: begin
          if (r_turn == TURN_LAST) begin
            w_state_nxt = S_OVER;
          end else begin
            w_state_nxt = S_RESOLVE;
            w_turn_nxt  = r_turn + 4'd1;
          end
        end
        S_RESOLVE: w_state_nxt = S_PLAYER;
        S_OVER:    w_state_nxt = S_TITLE;
        default:   w_state_nxt = S_TITLE;
      endcase
    end
  end

  assign state_out        = r_state;
  assign turn_out         = r_turn;
  assign rotate_out       = r_rotate;
  assign phase_change_out = r_phase_change;
  assign timeout_out      = r_timeout;

endmodule
